lcd_refresh_sink: RTL
=====================

Name: lcd_refresh_sink

Overview:
- Consumer end of the background-refresh word stream, sitting between the refresh generator and the LCD pins.
- Arms the generator with `enable`, captures each word strobed by `data_ok` into a small FIFO, and replays the words onto the 16-bit 8080-style LCD write bus with programmable WR timing.
- Applies flow control through `enable` and pulses `done` once the word flagged by `refresh_ok` has left the bus.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 4.
- WR_LOW, 2: pclk cycles `lcd_wr_n` is held low per word; minimum 1.
- WR_HIGH, 2: pclk cycles `lcd_wr_n` is held high after the rising edge, with data held; minimum 1.

Ports:
- pclk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request to begin a refresh; ignored unless the top FSM is IDLE.
- bg_sel  in  7  background select; latched on accepted `start`.
- refresh_req  out  7  latched `bg_sel`, driven to the generator.
- enable  out  1  arms the generator for the next word.
- refresh_data  in  16  word from the generator; valid only with `data_ok`.
- refresh_rs  in  1  word type: 0 = command, 1 = data; valid with `data_ok`.
- data_ok  in  1  one-cycle word strobe.
- refresh_ok  in  1  last-word flag; coincident with `data_ok`.
- lcd_cs_n  out  1  chip select, active low.
- lcd_rs  out  1  register select.
- lcd_wr_n  out  1  write strobe; the panel latches on the rising edge.
- lcd_rd_n  out  1  read strobe; constant 1.
- lcd_data  out  16  bus data.
- busy  out  1  high whenever the top FSM is not IDLE.
- done  out  1  one-cycle pulse at refresh completion.

Behaviour:
- Reset: `enable`=0, `refresh_req`=0, `lcd_cs_n`=1, `lcd_wr_n`=1, `lcd_rd_n`=1, `lcd_rs`=0, `lcd_data`=0, `busy`=0, `done`=0; FIFO emptied; both FSMs to idle.
  - Reset asserted mid-refresh aborts immediately: bus released, queued words discarded.
- Top FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on `start`, latch `bg_sel` and go to RUN.
  - RUN: `enable` = (count < DEPTH-1), registered.
    - The generator samples `enable` only between words and has at most one word in flight, so this threshold guarantees no overflow.
    - On `data_ok && refresh_ok`, push the word tagged `last`, drop `enable` next cycle, go to DRAIN.
  - DRAIN: `enable`=0; when the FIFO is empty and the bus FSM is B_IDLE, go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `data_ok` outside RUN: word dropped, sticky `err_ovf` debug flag set; a push into a full FIFO also sets `err_ovf` and drops the word. Neither is expected in normal operation.
- FIFO: storage 16+1+1 bits (data, rs, last); pointer width log2(DEPTH)+1 with wrap bit. Push and pop in the same cycle are both legal at any count, including full and empty.
- Bus FSM states: B_IDLE, B_LOW, B_HIGH.
  - B_IDLE: if the FIFO is non-empty, pop into the output register.
    - Drive `lcd_cs_n`=0, `lcd_rs`, `lcd_data` and `lcd_wr_n`=0 together; go to B_LOW.
  - B_LOW: hold for WR_LOW cycles; then `lcd_wr_n`=1 and go to B_HIGH.
  - B_HIGH: hold data and rs for WR_HIGH cycles, then B_IDLE.
    - If the next word is ready, it starts in that same cycle (back-to-back, `lcd_cs_n` stays 0).
    - Otherwise `lcd_cs_n`=1 with `lcd_data` and `lcd_rs` held.
- Word period on the bus is WR_LOW+WR_HIGH cycles.
  - The generator produces at most one word per 3 cycles; with defaults the bus (4 cycles) is the bottleneck and `enable` throttling is exercised.
- All outputs are registered; no combinational path from inputs to `lcd_*`.

Decomposition:
- `lcd_pkg`: top and bus state enums, FIFO entry struct {data[15:0], rs, last}, and the RS_CMD/RS_DATA constants.
- One sub-module, `lcd_word_fifo` (DEPTH-parameterised synchronous FIFO: push, pop, full, empty, count); the bus FSM and top FSM stay in `lcd_refresh_sink`.

Test Plan:
- Reset mid-word: `start`, wait until `lcd_wr_n`=0, assert `rst_n`=0 for 1 cycle -> next cycle `lcd_cs_n`=1, `lcd_wr_n`=1, `enable`=0, `busy`=0; no further bus activity.
- Single word: `start`, `bg_sel`=0; drive one word 16'h002A, rs=0 with `refresh_ok`=1 -> bus shows rs=0, data 16'h002A, `lcd_wr_n` low for exactly 2 cycles then high for 2; `done` pulses one cycle after the FIFO drains; `refresh_req`=0.
- Throttling: generator model at 1 word per 3 cycles, 40 words 16'h0000..16'h0027, rs alternating then 1 -> bus order and rs match exactly; `enable` drops whenever count=3; `err_ovf` stays 0.
- Back-to-back: WR_LOW=1, WR_HIGH=1, 3 words pre-queued -> `lcd_cs_n` stays 0 across all 3 words and `lcd_wr_n` toggles every cycle.
- Illegal strobe: `data_ok` pulse while IDLE -> no bus cycle, `err_ovf`=1, `busy`=0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types for the LCD refresh sink: FSM encodings, the FIFO entry
// layout and the register-select encodings used on the 8080 bus.
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } top_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_LOW,
        B_HIGH
    } bus_state_t;

    // One queued bus word: payload, register select and end-of-refresh tag.
    typedef struct packed {
        logic [15:0] data;
        logic        rs;
        logic        last;
    } fifo_entry_t;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

endpackage

// File: rtl/lcd_word_fifo.sv
// Synchronous word FIFO between the refresh generator and the bus FSM.
// Pointers carry an extra wrap bit so full and empty are unambiguous.
// Push and pop in the same cycle are honoured at every fill level.
module lcd_word_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     pclk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fifo_entry_t              wdata,
    input  logic                     pop,
    output fifo_entry_t              rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t     mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            do_push;
    logic            do_pop;

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == (AW + 1)'(DEPTH));
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge pclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/lcd_refresh_sink.sv
// Consumer end of the background-refresh stream. Arms the generator with
// enable, queues strobed words and replays them onto the 16-bit 8080 LCD
// write bus with programmable WR low/high timing. done pulses once the
// last word of the refresh has left the bus.
module lcd_refresh_sink
    import lcd_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  bg_sel,
    output logic [6:0]  refresh_req,
    output logic        enable,
    input  logic [15:0] refresh_data,
    input  logic        refresh_rs,
    input  logic        data_ok,
    input  logic        refresh_ok,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic [15:0] lcd_data,
    output logic        busy,
    output logic        done
);

    localparam int              CW        = $clog2(DEPTH) + 1;
    // With one word in flight and enable sampled between words, stopping
    // at DEPTH-1 leaves room for the straggler.
    localparam logic [CW-1:0]   EN_LIMIT  = CW'(DEPTH - 1);
    localparam int              TMAX      = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
    localparam int              TW        = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0]   LOW_LAST  = TW'(WR_LOW - 1);
    localparam logic [TW-1:0]   HIGH_LAST = TW'(WR_HIGH - 1);

    top_state_t     state_q, state_d;
    bus_state_t     bstate_q, bstate_d;
    logic [TW-1:0]  bcnt_q, bcnt_d;

    fifo_entry_t    push_entry;
    fifo_entry_t    head;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic [CW-1:0]  count;

    logic           run_strobe;
    logic           err_ovf;

    logic           wr_n_d;
    logic           cs_n_d;
    logic           rs_d;
    logic [15:0]    data_d;

    // The last tag is carried for debug visibility; completion is detected
    // from the FIFO and bus FSM both going idle.
    logic           unused_last;
    assign unused_last = head.last;

    assign lcd_rd_n = 1'b1;

    assign push_entry = '{data: refresh_data, rs: refresh_rs, last: refresh_ok};
    assign run_strobe = data_ok && (state_q == RUN);
    assign push       = run_strobe && (!full || pop);

    lcd_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .pclk  (pclk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Top FSM next state: arm, collect until the last word, drain, report.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (data_ok && refresh_ok) state_d = DRAIN;
            DRAIN:   if (empty && (bstate_q == B_IDLE)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Top FSM state plus its registered outputs and the overflow flag.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            refresh_req <= '0;
            enable      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
            enable  <= (state_d == RUN) && (count < EN_LIMIT);
            if ((state_q == IDLE) && start) refresh_req <= bg_sel;
            // Strobes outside RUN, or into a full FIFO, are dropped and flagged.
            if (data_ok && !push) err_ovf <= 1'b1;
        end
    end

    // Bus FSM next state: pop a word, hold WR low, then high, chaining words
    // directly from the last high cycle when the FIFO has one ready.
    always_comb begin
        bstate_d = bstate_q;
        bcnt_d   = bcnt_q;
        pop      = 1'b0;
        wr_n_d   = lcd_wr_n;
        cs_n_d   = lcd_cs_n;
        rs_d     = lcd_rs;
        data_d   = lcd_data;
        case (bstate_q)
            B_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    cs_n_d   = 1'b0;
                    wr_n_d   = 1'b0;
                    rs_d     = head.rs;
                    data_d   = head.data;
                    bcnt_d   = '0;
                    bstate_d = B_LOW;
                end
            end
            B_LOW: begin
                if (bcnt_q == LOW_LAST) begin
                    wr_n_d   = 1'b1;
                    bcnt_d   = '0;
                    bstate_d = B_HIGH;
                end else begin
                    bcnt_d = bcnt_q + TW'(1);
                end
            end
            B_HIGH: begin
                if (bcnt_q == HIGH_LAST) begin
                    bcnt_d = '0;
                    if (!empty) begin
                        pop      = 1'b1;
                        wr_n_d   = 1'b0;
                        rs_d     = head.rs;
                        data_d   = head.data;
                        bstate_d = B_LOW;
                    end else begin
                        // Release chip select; data and rs stay on the pins.
                        cs_n_d   = 1'b1;
                        bstate_d = B_IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q + TW'(1);
                end
            end
            default: bstate_d = B_IDLE;
        endcase
    end

    // Bus FSM state and the registered LCD pins.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            bstate_q <= B_IDLE;
            bcnt_q   <= '0;
            lcd_cs_n <= 1'b1;
            lcd_wr_n <= 1'b1;
            lcd_rs   <= RS_CMD;
            lcd_data <= '0;
        end else begin
            bstate_q <= bstate_d;
            bcnt_q   <= bcnt_d;
            lcd_cs_n <= cs_n_d;
            lcd_wr_n <= wr_n_d;
            lcd_rs   <= rs_d;
            lcd_data <= data_d;
        end
    end

endmodule
